imm_ext_pipe: RTL and testbench
===============================

Name: imm_ext_pipe

Overview:
Parametrised, pipelined successor of the datapath immediate extender. It accepts an immediate plus an extension opcode over a valid/ready handshake and produces the extended word one cycle later on a registered output. A 2-entry elastic buffer (output register plus skid register) sustains full throughput under back-pressure. Adds wider configurable widths, a zero-extend-and-shift mode, illegal-opcode flagging, a saturating illegal-opcode counter and a pass-through tag. It sits between decode and the execute operand mux.

Parameters:
IMM_W, 16, immediate input width (1..DATA_W-1)
DATA_W, 32, extended output width
BR_SHIFT, 2, left shift for branch-offset modes (IMM_W+BR_SHIFT <= DATA_W)
TAG_W, 5, width of the opaque tag carried alongside each item
CNT_W, 8, width of the illegal-opcode counter

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
in_valid  in  1  upstream item present
in_ready  out  1  block can accept an item this cycle
in_imm  in  IMM_W  immediate
in_op  in  3  extension opcode
in_tag  in  TAG_W  opaque tag (e.g. destination register index)
out_valid  out  1  out_data/out_tag/out_err valid
out_ready  in  1  downstream accepts
out_data  out  DATA_W  extended result
out_tag  out  TAG_W  tag of the item
out_err  out  1  item had an illegal opcode
err_cnt  out  CNT_W  saturating count of accepted illegal items
cnt_clr  in  1  synchronous clear of err_cnt

Behaviour:
- Opcodes:
  - 0: sign-extend.
  - 1: zero-extend.
  - 2: imm placed in the top IMM_W bits, low bits 0.
  - 3: sign-extend, then shift left BR_SHIFT.
  - 4: zero-extend, then shift left BR_SHIFT.
  - 5-7: illegal; result all-zero and err=1.
- The result is computed combinationally at input and captured at accept. No truncation, because IMM_W+BR_SHIFT <= DATA_W.
- Accept (in transfer) = in_valid & in_ready. Deliver (out transfer) = out_valid & out_ready.
- in_ready = !skid_full. It depends only on registered state, so there is no combinational path from out_ready.
- Latency: an item accepted in cycle N is presented in cycle N+1 when the output stage is empty or being drained.
- Per cycle, with out_slot free meaning !out_valid | out_ready:
  - Skid full and out_slot free: skid moves to output; skid empties; in_ready was 0, so nothing is accepted.
  - Skid empty, accept, out_slot free: item goes to the output register.
  - Skid empty, accept, out_slot not free: item goes to the skid register; in_ready becomes 0 next cycle.
  - Output delivered with no replacement: out_valid drops to 0.
- Order is strictly FIFO. Maximum occupancy is 2. Throughput is 1 item/cycle with out_ready held high.
- out_data, out_tag and out_err hold stable while out_valid=1 and out_ready=0.
- err_cnt:
  - Increments by 1 per accepted item with an illegal opcode (counted at accept, not delivery).
  - Saturates at 2^CNT_W-1.
  - cnt_clr has priority: the counter becomes 0 even if an illegal item is accepted in the same cycle.
- Reset (reset=0 at an edge), also valid mid-operation:
  - Both stages are emptied; in-flight items are discarded.
  - out_valid=0, out_data=0, out_tag=0, out_err=0, err_cnt=0.
  - in_ready=1 in the first cycle after reset deasserts.
- Inputs are ignored when in_valid=0. Data registers load only on a transfer.

Decomposition:
- Shared package holds:
  - opcode constants EXT_SIGN=0, EXT_ZERO=1, EXT_HIGH=2, EXT_SBR=3, EXT_ZBR=4;
  - the opcode width constant 3;
  - a packed item struct {data, tag, err}.
- One natural sub-module: imm_ext_core, the combinational parametrised extender (imm, op -> data, err).
- The top level holds the 2-entry elastic buffer and the counter.

Test Plan:
- Defaults, out_ready=1, accept imm=16'h8001 with ops 0..4 on consecutive cycles -> one cycle later, in order, out_data = FFFF8001, 00008001, 80010000, FFFE0004, 00020004; out_err=0 throughout.
- op=5, imm=16'h1234, tag=7 -> out_data=0, out_err=1, out_tag=7, err_cnt=1. Then 255 more illegal items with CNT_W=8 -> err_cnt stays at 255. Then cnt_clr together with an illegal accept -> err_cnt=0.
- out_ready=0; send A, B -> in_ready=0 after B is accepted, C is held. Raise out_ready -> A, B, C delivered in order, with out_data stable during the stall.
- Random in_valid and out_ready at 50% for 10k items -> scoreboard matches in order with no loss or duplication; in_ready never depends combinationally on out_ready.
- Buffer full (2 items), assert reset=0 for one cycle -> out_valid=0, err_cnt=0, in_ready=1 next cycle; the next accepted item appears alone.
- Parameter sweep IMM_W=12, DATA_W=24, BR_SHIFT=1, imm=12'h800, op=3 -> out_data=24'hFFF000.

Source files
------------

// File: rtl/imm_ext_pipe_pkg.sv
// ----------------------------------------------------------------------------
// imm_ext_pipe_pkg
// Shared definitions for the pipelined immediate extender:
//   - extension opcode width and opcode encodings
//   - default widths and the packed item struct carried through the buffer
//     for the default configuration (DATA_W=32, TAG_W=5)
// ----------------------------------------------------------------------------
package imm_ext_pipe_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] EXT_SIGN = 3'd0;
    localparam logic [OP_W-1:0] EXT_ZERO = 3'd1;
    localparam logic [OP_W-1:0] EXT_HIGH = 3'd2;
    localparam logic [OP_W-1:0] EXT_SBR  = 3'd3;
    localparam logic [OP_W-1:0] EXT_ZBR  = 3'd4;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_TAG_W  = 5;

    // One buffered item at the default widths; the top level declares an
    // equivalent struct sized by its own parameters.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic [DEF_TAG_W-1:0]  tag;
        logic                  err;
    } ext_item_t;

endpackage

// File: rtl/imm_ext_pipe_core.sv
// ----------------------------------------------------------------------------
// imm_ext_core
// Purely combinational, parametrised immediate extender.
// Ports:
//   imm  in  IMM_W   immediate to extend
//   op   in  OP_W    extension opcode (EXT_* in imm_ext_pipe_pkg)
//   data out DATA_W  extended word (all-zero for illegal opcodes)
//   err  out 1       opcode was illegal (5..7)
// ----------------------------------------------------------------------------
module imm_ext_core
    import imm_ext_pipe_pkg::*;
#(
    parameter int IMM_W    = 16,
    parameter int DATA_W   = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic [IMM_W-1:0]  imm,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] data,
    output logic              err
);

    logic [DATA_W-1:0] sext;
    logic [DATA_W-1:0] zext;

    assign sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign zext = {{(DATA_W-IMM_W){1'b0}}, imm};

    // IMM_W+BR_SHIFT never exceeds DATA_W, so the shifted modes lose no
    // significant bits.
    always_comb begin
        data = '0;
        err  = 1'b0;
        case (op)
            EXT_SIGN: data = sext;
            EXT_ZERO: data = zext;
            EXT_HIGH: data = {imm, {(DATA_W-IMM_W){1'b0}}};
            EXT_SBR:  data = sext << BR_SHIFT;
            EXT_ZBR:  data = zext << BR_SHIFT;
            default:  err  = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// ----------------------------------------------------------------------------
// imm_ext_pipe
// Pipelined immediate extender with a 2-entry elastic buffer (output register
// plus skid register) and a saturating illegal-opcode counter.
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   in_valid/in_ready     upstream handshake; in_imm, in_op, in_tag payload
//   out_valid/out_ready   downstream handshake; out_data, out_tag, out_err
//   err_cnt               saturating count of accepted illegal items
//   cnt_clr               synchronous clear of err_cnt (wins over increment)
// ----------------------------------------------------------------------------
module imm_ext_pipe
    import imm_ext_pipe_pkg::*;
#(
    parameter int IMM_W    = 16,
    parameter int DATA_W   = 32,
    parameter int BR_SHIFT = 2,
    parameter int TAG_W    = 5,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [OP_W-1:0]   in_op,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err,
    output logic [CNT_W-1:0]  err_cnt,
    input  logic              cnt_clr
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic              err;
    } item_t;

    item_t new_item;
    item_t out_q;
    item_t skid_q;
    logic  out_valid_q;
    logic  skid_full_q;
    logic  accept;
    logic  slot_free;

    imm_ext_core #(
        .IMM_W   (IMM_W),
        .DATA_W  (DATA_W),
        .BR_SHIFT(BR_SHIFT)
    ) u_core (
        .imm (in_imm),
        .op  (in_op),
        .data(new_item.data),
        .err (new_item.err)
    );

    assign new_item.tag = in_tag;

    // in_ready comes only from registered state, which keeps out_ready off
    // any combinational path back to the upstream stage.
    assign in_ready  = !skid_full_q;
    assign accept    = in_valid && in_ready;
    assign slot_free = !out_valid_q || out_ready;

    // Elastic buffer. While the skid holds an item nothing is accepted, so
    // the skid always drains into the output register before new data can
    // enter, preserving FIFO order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            skid_full_q <= 1'b0;
        end else if (skid_full_q) begin
            if (slot_free) begin
                out_q       <= skid_q;
                out_valid_q <= 1'b1;
                skid_full_q <= 1'b0;
            end
        end else if (accept) begin
            if (slot_free) begin
                out_q       <= new_item;
                out_valid_q <= 1'b1;
            end else begin
                skid_q      <= new_item;
                skid_full_q <= 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Illegal items are counted when accepted, not when delivered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_cnt <= '0;
        end else if (cnt_clr) begin
            err_cnt <= '0;
        end else if (accept && new_item.err && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_q.data;
    assign out_tag   = out_q.tag;
    assign out_err   = out_q.err;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// ----------------------------------------------------------------------------
// tb_imm_ext_pipe
// Directed self-checking bench for imm_ext_pipe (default configuration) plus a
// second instance at IMM_W=12, DATA_W=24, BR_SHIFT=1. Inputs change and
// outputs are sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [2:0]  in_op;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        out_err;
    logic [7:0]  err_cnt;
    logic        cnt_clr;

    logic        in_valid2;
    logic        in_ready2;
    logic [11:0] in_imm2;
    logic [2:0]  in_op2;
    logic [4:0]  in_tag2;
    logic        out_valid2;
    logic [23:0] out_data2;
    logic [4:0]  out_tag2;
    logic        out_err2;
    logic [7:0]  err_cnt2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imm_ext_pipe dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_imm   (in_imm),
        .in_op    (in_op),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_tag  (out_tag),
        .out_err  (out_err),
        .err_cnt  (err_cnt),
        .cnt_clr  (cnt_clr)
    );

    imm_ext_pipe #(
        .IMM_W   (12),
        .DATA_W  (24),
        .BR_SHIFT(1),
        .TAG_W   (5),
        .CNT_W   (8)
    ) dut2 (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid2),
        .in_ready (in_ready2),
        .in_imm   (in_imm2),
        .in_op    (in_op2),
        .in_tag   (in_tag2),
        .out_valid(out_valid2),
        .out_ready(1'b1),
        .out_data (out_data2),
        .out_tag  (out_tag2),
        .out_err  (out_err2),
        .err_cnt  (err_cnt2),
        .cnt_clr  (1'b0)
    );

    // Reference extender for the default widths, written with integer
    // arithmetic: returns {err, data}.
    function automatic logic [32:0] model(input logic [15:0] imm, input logic [2:0] op);
        int          si;
        logic [31:0] u;
        si = int'($signed(imm));
        u  = 32'(imm);
        case (op)
            3'd0:    return {1'b0, 32'(si)};
            3'd1:    return {1'b0, u};
            3'd2:    return {1'b0, u * 32'd65536};
            3'd3:    return {1'b0, 32'(si * 4)};
            3'd4:    return {1'b0, u * 32'd4};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (out_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_out_data got=%h exp=0", out_data); end
        checks++;
        if (out_tag !== 5'd0 || out_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_tag_err got=%h/%b exp=0/0", out_tag, out_err); end
        checks++;
        if (err_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_ops();
        logic [31:0] exp_data [5];
        exp_data[0] = 32'hFFFF8001;
        exp_data[1] = 32'h00008001;
        exp_data[2] = 32'h80010000;
        exp_data[3] = 32'hFFFE0004;
        exp_data[4] = 32'h00020004;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_imm   = 16'h8001;
            in_op    = 3'(i);
            in_tag   = 5'(i + 10);
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_data[i] || out_err !== 1'b0 || out_tag !== 5'(i + 10)) begin
                errors++;
                $display("[TB] FAIL op%0d got v=%b d=%h e=%b t=%0d exp v=1 d=%h e=0 t=%0d",
                         i, out_valid, out_data, out_err, out_tag, exp_data[i], i + 10);
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ops_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_imm    = 16'h1234;
        in_op     = 3'd5;
        in_tag    = 5'd7;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'd0 || out_err !== 1'b1 || out_tag !== 5'd7) begin
            errors++;
            $display("[TB] FAIL illegal_item got v=%b d=%h e=%b t=%0d exp v=1 d=0 e=1 t=7",
                     out_valid, out_data, out_err, out_tag);
        end
        checks++;
        if (err_cnt !== 8'd1) begin errors++; $display("[TB] FAIL illegal_cnt1 got=%0d exp=1", err_cnt); end
        for (int i = 0; i < 255; i++) begin
            in_op = 3'(5 + (i % 3));
            step();
        end
        checks++;
        if (err_cnt !== 8'd255) begin errors++; $display("[TB] FAIL cnt_saturate got=%0d exp=255", err_cnt); end
        cnt_clr = 1'b1;
        in_op   = 3'd6;
        step();
        cnt_clr = 1'b0;
        checks++;
        if (err_cnt !== 8'd0) begin errors++; $display("[TB] FAIL cnt_clr_priority got=%0d exp=0", err_cnt); end
        in_valid = 1'b0;
        step();
        checks++;
        if (err_cnt !== 8'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL illegal_idle got cnt=%0d v=%b exp cnt=0 v=0", err_cnt, out_valid);
        end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_imm    = 16'h00F0;
        in_op     = 3'd1;
        in_tag    = 5'd1;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h000000F0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_a got v=%b d=%h r=%b exp v=1 d=000000f0 r=1", out_valid, out_data, in_ready);
        end
        in_imm = 16'hFFFF;
        in_op  = 3'd0;
        in_tag = 5'd2;
        step();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_full_ready got=%b exp=0", in_ready); end
        in_imm = 16'h0003;
        in_op  = 3'd2;
        in_tag = 5'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_data !== 32'h000000F0 || out_tag !== 5'd1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_stall%0d got d=%h t=%0d v=%b r=%b exp d=000000f0 t=1 v=1 r=0",
                         i, out_data, out_tag, out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_comb got=%b exp=0", in_ready); end
        step();
        checks++;
        if (out_data !== 32'hFFFFFFFF || out_tag !== 5'd2 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_b got d=%h t=%0d r=%b exp d=ffffffff t=2 r=1", out_data, out_tag, in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h00030000 || out_tag !== 5'd3) begin
            errors++;
            $display("[TB] FAIL bp_c got v=%b d=%h t=%0d exp v=1 d=00030000 t=3", out_valid, out_data, out_tag);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_random();
        logic [32:0] q_exp [$];
        logic [4:0]  q_tag [$];
        logic [32:0] exp_item;
        logic [4:0]  exp_tag;
        logic        hold;
        logic        acc;
        int          sent;
        int          recv;
        int          cycles;
        int          shown;
        hold   = 1'b0;
        sent   = 0;
        recv   = 0;
        cycles = 0;
        shown  = 0;
        while ((sent < 10000 || recv < sent) && cycles < 60000) begin
            if (!hold) begin
                if (sent < 10000 && $urandom_range(1) == 1) begin
                    in_valid = 1'b1;
                    in_imm   = 16'($urandom);
                    in_op    = 3'($urandom_range(7));
                    in_tag   = 5'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(1) == 1);
            #2;
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                checks++;
                if (q_exp.size() == 0) begin
                    errors++;
                    if (shown < 10) $display("[TB] FAIL rand_extra got d=%h t=%0d exp none", out_data, out_tag);
                    shown++;
                end else begin
                    exp_item = q_exp.pop_front();
                    exp_tag  = q_tag.pop_front();
                    recv++;
                    if ({out_err, out_data} !== exp_item || out_tag !== exp_tag) begin
                        errors++;
                        if (shown < 10)
                            $display("[TB] FAIL rand_item%0d got e=%b d=%h t=%0d exp e=%b d=%h t=%0d",
                                     recv, out_err, out_data, out_tag, exp_item[32], exp_item[31:0], exp_tag);
                        shown++;
                    end
                end
            end
            if (acc) begin
                q_exp.push_back(model(in_imm, in_op));
                q_tag.push_back(in_tag);
                sent++;
            end
            hold = in_valid && !acc;
            step();
            cycles++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (recv !== 10000 || q_exp.size() != 0) begin
            errors++;
            $display("[TB] FAIL rand_count got recv=%0d left=%0d exp recv=10000 left=0", recv, q_exp.size());
        end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_imm    = 16'h5555;
        in_op     = 3'd7;
        in_tag    = 5'd9;
        cnt_clr   = 1'b1;
        step();
        cnt_clr = 1'b0;
        in_tag  = 5'd10;
        step();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || err_cnt !== 8'd1) begin
            errors++;
            $display("[TB] FAIL mid_full got r=%b cnt=%0d exp r=0 cnt=1", in_ready, err_cnt);
        end
        reset = 1'b0;
        step();
        reset = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || err_cnt !== 8'd0 || in_ready !== 1'b1 || out_data !== 32'd0 || out_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset got v=%b cnt=%0d r=%b d=%h e=%b exp v=0 cnt=0 r=1 d=0 e=0",
                     out_valid, err_cnt, in_ready, out_data, out_err);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_imm    = 16'h0042;
        in_op     = 3'd1;
        in_tag    = 5'd21;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h00000042 || out_tag !== 5'd21) begin
            errors++;
            $display("[TB] FAIL mid_next got v=%b d=%h t=%0d exp v=1 d=00000042 t=21", out_valid, out_data, out_tag);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_alone got=%b exp=0", out_valid); end
    endtask

    task automatic test_param_sweep();
        logic [11:0] imms [3];
        logic [2:0]  ops  [3];
        logic [23:0] exps [3];
        imms[0] = 12'h800; ops[0] = 3'd3; exps[0] = 24'hFFF000;
        imms[1] = 12'h801; ops[1] = 3'd4; exps[1] = 24'h001002;
        imms[2] = 12'hABC; ops[2] = 3'd2; exps[2] = 24'hABC000;
        for (int i = 0; i < 3; i++) begin
            in_valid2 = 1'b1;
            in_imm2   = imms[i];
            in_op2    = ops[i];
            in_tag2   = 5'(i);
            step();
            checks++;
            if (out_valid2 !== 1'b1 || out_data2 !== exps[i] || out_err2 !== 1'b0 || out_tag2 !== 5'(i)) begin
                errors++;
                $display("[TB] FAIL sweep%0d got v=%b d=%h e=%b t=%0d exp v=1 d=%h e=0 t=%0d",
                         i, out_valid2, out_data2, out_err2, out_tag2, exps[i], i);
            end
        end
        in_valid2 = 1'b0;
        step();
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_imm    = '0;
        in_op     = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        in_valid2 = 1'b0;
        in_imm2   = '0;
        in_op2    = '0;
        in_tag2   = '0;
        #1;
        test_reset();
        test_ops();
        test_illegal();
        test_back_pressure();
        test_random();
        test_reset_mid();
        test_param_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
